// File: rtl/bist_fail_logger_if.sv
// BIST fail-logger bus: fail capture from the BIST compare stage,
// readout pops, and the repair verdict.
interface bist_fail_logger_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LOG_DEPTH  = 8,
  parameter int CNT_WIDTH  = 10
);
  localparam int UW = $clog2(LOG_DEPTH) + 1;

  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic                  bist_done;
  logic                  clear;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic                  empty;
  logic [UW-1:0]         unique_cnt;
  logic [CNT_WIDTH-1:0]  total_fails;
  logic                  overflow;
  logic                  verdict_valid;
  logic                  repairable;

  modport master (
    output fail, fail_addr, bist_done, clear, rd_en,
    input  rd_addr, rd_valid, empty, unique_cnt, total_fails,
           overflow, verdict_valid, repairable
  );

  modport slave (
    input  fail, fail_addr, bist_done, clear, rd_en,
    output rd_addr, rd_valid, empty, unique_cnt, total_fails,
           overflow, verdict_valid, repairable
  );
endinterface

// File: rtl/bist_fail_logger.sv
// Logs unique BIST fail addresses into a small CAM-style log, counts all
// fails, and issues a spare-word repair verdict once BIST is done.
module bist_fail_logger #(
  parameter int ADDR_WIDTH = 8,
  parameter int LOG_DEPTH  = 8,
  parameter int SPARES     = 2,
  parameter int CNT_WIDTH  = 10
) (
  input  logic               clk,
  input  logic               rst,
  bist_fail_logger_if.slave  bus
);
  localparam int PW = $clog2(LOG_DEPTH);

  typedef enum logic [1:0] {COLLECT, EVAL, REPORT} state_e;

  state_e                               state_q, state_d;
  logic [LOG_DEPTH-1:0][ADDR_WIDTH-1:0] log_mem;
  logic [PW:0]                          wr_ptr, rd_ptr;
  logic [LOG_DEPTH-1:0]                 match;
  logic [CNT_WIDTH-1:0]                 total_q;
  logic [ADDR_WIDTH-1:0]                rd_addr_q;
  logic hit, full, empty, log_fire, do_write, rd_fire;
  logic overflow_q, verdict_q, repair_q, rd_valid_q;

  // Entries below wr_ptr are valid; the log never wraps, so this is the valid mask.
  for (genvar i = 0; i < LOG_DEPTH; i++) begin : g_cmp
    assign match[i] = ((PW+1)'(i) < wr_ptr) && (log_mem[i] == bus.fail_addr);
  end

  assign hit      = |match;
  assign full     = wr_ptr[PW];
  assign empty    = (rd_ptr == wr_ptr);
  assign log_fire = (state_q == COLLECT) && bus.fail && !bus.clear && !rst;
  assign do_write = log_fire && !hit && !full;
  assign rd_fire  = (state_q == REPORT) && bus.rd_en && !empty && !bus.clear;

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) state_d = COLLECT;
    else begin
      case (state_q)
        COLLECT: if (bus.bist_done) state_d = EVAL;
        EVAL:    state_d = REPORT;
        REPORT:  state_d = REPORT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // Array contents are left stale on reset/clear; wr_ptr alone defines validity.
  always_ff @(posedge clk) begin
    if (do_write) log_mem[wr_ptr[PW-1:0]] <= bus.fail_addr;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
      verdict_q  <= 1'b0;
      repair_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      if (do_write)                       wr_ptr     <= wr_ptr + 1'b1;
      if (log_fire && !hit && full)       overflow_q <= 1'b1;
      if (log_fire && (total_q != '1))    total_q    <= total_q + 1'b1;
      // EVAL sees counters that already include a fail logged alongside bist_done.
      if (state_q == EVAL) begin
        verdict_q <= 1'b1;
        repair_q  <= !overflow_q && (int'(wr_ptr) <= SPARES);
      end
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_addr_q <= log_mem[rd_ptr[PW-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  assign bus.rd_addr       = rd_addr_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.empty         = empty;
  assign bus.unique_cnt    = wr_ptr;
  assign bus.total_fails   = total_q;
  assign bus.overflow      = overflow_q;
  assign bus.verdict_valid = verdict_q;
  assign bus.repairable    = repair_q;
endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed checks of bist_fail_logger: logging, dedup, overflow, verdict,
// readout, clear and reset behaviour.
module tb_bist_fail_logger;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bist_fail_logger_if #(.ADDR_WIDTH(8), .LOG_DEPTH(8), .CNT_WIDTH(10)) bus ();

  bist_fail_logger #(.ADDR_WIDTH(8), .LOG_DEPTH(8), .SPARES(2), .CNT_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fail = 1'b0; bus.fail_addr = '0; bus.bist_done = 1'b0;
    bus.clear = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rd_addr"},  32'(bus.rd_addr), 0);
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 0);
    chk({tag, ".empty"},    32'(bus.empty), 1);
    chk({tag, ".uniq"},     32'(bus.unique_cnt), 0);
    chk({tag, ".total"},    32'(bus.total_fails), 0);
    chk({tag, ".ovf"},      32'(bus.overflow), 0);
    chk({tag, ".vv"},       32'(bus.verdict_valid), 0);
    chk({tag, ".rep"},      32'(bus.repairable), 0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  task automatic send_fail(input logic [7:0] a);
    bus.fail = 1'b1; bus.fail_addr = a; tick(); bus.fail = 1'b0;
  endtask

  // bist_done pulse, then one more cycle so the verdict is in REPORT.
  task automatic finish_bist();
    bus.bist_done = 1'b1; tick(); bus.bist_done = 1'b0; tick();
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    chk({tag, ".rdv"},  32'(bus.rd_valid), 1);
    chk({tag, ".addr"}, 32'(bus.rd_addr), 32'(exp));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk_reset_vals("rst");

    // No fails: verdict two cycles after bist_done, repairable.
    bus.bist_done = 1'b1; tick(); bus.bist_done = 1'b0;
    chk("nofail.vv_eval", 32'(bus.verdict_valid), 0);
    tick();
    chk("nofail.vv",    32'(bus.verdict_valid), 1);
    chk("nofail.rep",   32'(bus.repairable), 1);
    chk("nofail.empty", 32'(bus.empty), 1);
    chk("nofail.total", 32'(bus.total_fails), 0);

    // 0x12, 0x34, 0x12 back to back; repeat must be a hit.
    do_clear();
    send_fail(8'h12); send_fail(8'h34); send_fail(8'h12);
    finish_bist();
    chk("dup.uniq",  32'(bus.unique_cnt), 2);
    chk("dup.total", 32'(bus.total_fails), 3);
    chk("dup.rep",   32'(bus.repairable), 1);
    chk("dup.empty", 32'(bus.empty), 0);
    pop("dup.p0", 8'h12);
    pop("dup.p1", 8'h34);
    tick();
    chk("dup.rdv_drop", 32'(bus.rd_valid), 0);
    chk("dup.empty2",   32'(bus.empty), 1);
    chk("dup.uniq2",    32'(bus.unique_cnt), 2);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    chk("dup.rd_empty.rdv",  32'(bus.rd_valid), 0);
    chk("dup.rd_empty.hold", 32'(bus.rd_addr), 32'h34);

    // Nine distinct addresses overflow an 8-deep log.
    do_clear();
    for (int i = 0; i < 9; i++) send_fail(8'(i));
    chk("ovf.full_not_empty", 32'(bus.empty), 0);
    finish_bist();
    chk("ovf.ovf",   32'(bus.overflow), 1);
    chk("ovf.uniq",  32'(bus.unique_cnt), 8);
    chk("ovf.total", 32'(bus.total_fails), 9);
    chk("ovf.rep",   32'(bus.repairable), 0);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ovf.p%0d.rdv", i),  32'(bus.rd_valid), 1);
      chk($sformatf("ovf.p%0d.addr", i), 32'(bus.rd_addr), 32'(i));
    end
    tick();
    bus.rd_en = 1'b0;
    chk("ovf.p8.rdv",  32'(bus.rd_valid), 0);
    chk("ovf.p8.hold", 32'(bus.rd_addr), 32'h07);
    chk("ovf.vv_keep", 32'(bus.verdict_valid), 1);

    // Fail coincident with bist_done is logged; fail in EVAL and rd_en in COLLECT ignored.
    do_clear();
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    chk("coll.rd_ignored", 32'(bus.rd_valid), 0);
    bus.fail = 1'b1; bus.fail_addr = 8'hFF; bus.bist_done = 1'b1; tick();
    bus.bist_done = 1'b0; bus.fail_addr = 8'h44;
    chk("edge.uniq_eval", 32'(bus.unique_cnt), 1);
    tick(); bus.fail = 1'b0;
    chk("edge.uniq",  32'(bus.unique_cnt), 1);
    chk("edge.total", 32'(bus.total_fails), 1);
    chk("edge.vv",    32'(bus.verdict_valid), 1);
    chk("edge.rep",   32'(bus.repairable), 1);
    pop("edge.p0", 8'hFF);

    // Three uniques exceed two spares; clear beats rd_en and fail in the same cycle.
    do_clear();
    send_fail(8'h01); send_fail(8'h02); send_fail(8'h03);
    finish_bist();
    chk("clr.rep3", 32'(bus.repairable), 0);
    chk("clr.vv3",  32'(bus.verdict_valid), 1);
    bus.clear = 1'b1; bus.rd_en = 1'b1; bus.fail = 1'b1; bus.fail_addr = 8'h09;
    tick();
    idle_inputs();
    chk_reset_vals("clr");
    send_fail(8'h05);
    finish_bist();
    chk("clr.uniq_new", 32'(bus.unique_cnt), 1);
    pop("clr.p0", 8'h05);

    // Reset in the middle of a pop stream.
    do_clear();
    send_fail(8'hA0); send_fail(8'hA1); send_fail(8'hA2);
    finish_bist();
    bus.rd_en = 1'b1; tick();
    chk("rstpop.rdv_pre", 32'(bus.rd_valid), 1);
    rst = 1'b1; tick(); rst = 1'b0; bus.rd_en = 1'b0;
    chk("rstpop.rdv",   32'(bus.rd_valid), 0);
    chk("rstpop.empty", 32'(bus.empty), 1);
    chk("rstpop.vv",    32'(bus.verdict_valid), 0);
    chk("rstpop.uniq",  32'(bus.unique_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bist_fail_logger.md
BIST_FAIL_LOGGER -- requirements
Module: bist_fail_logger

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of the SRAM address (256 words).
REQ-002 Parameter LOG_DEPTH, default 8, number of unique fail-address entries stored; power of two, at least 2.
REQ-003 Parameter SPARES, default 2, number of spare words available for repair.
REQ-004 Parameter CNT_WIDTH, default 10, width of the total-fail counter.
REQ-005 clk  input  1  single clock; all logic updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 fail  input  1  one-cycle fail strobe from the BIST compare stage.
REQ-008 fail_addr  input  ADDR_WIDTH  failing address; qualified by fail.
REQ-009 bist_done  input  1  BIST controller reached DONE; level or pulse.
REQ-010 clear  input  1  discards the log and restarts collection.
REQ-011 rd_en  input  1  request to pop the oldest logged address.
REQ-012 rd_addr  output  ADDR_WIDTH  popped address; registered.
REQ-013 rd_valid  output  1  one-cycle pulse; rd_addr is valid.
REQ-014 empty  output  1  no unread entries remain.
REQ-015 unique_cnt  output  clog2(LOG_DEPTH)+1  number of unique addresses logged.
REQ-016 total_fails  output  CNT_WIDTH  all fail strobes seen, including repeats.
REQ-017 overflow  output  1  a new unique address arrived while the log was full.
REQ-018 verdict_valid  output  1  repair verdict is final.
REQ-019 repairable  output  1  repair verdict; qualified by verdict_valid.

Function
REQ-020 The FSM SHALL have three states: COLLECT, EVAL, REPORT.
REQ-021 COLLECT: on fail=1, fail_addr SHALL be compared against all valid entries in the same cycle.
- On a miss with the log not full: write the address at wr_ptr, then increment wr_ptr and unique_cnt.
- On a miss with the log full: set overflow sticky; the log is unchanged.
- On a hit: no write.
REQ-022 total_fails SHALL increment on every fail=1 in COLLECT, saturating at all-ones.
REQ-023 COLLECT -> EVAL when bist_done=1; a fail in that same cycle SHALL still be logged.
REQ-024 EVAL SHALL last exactly one cycle, then move to REPORT.
REQ-025 On entering REPORT:
- verdict_valid SHALL assert.
- repairable SHALL equal (!overflow && unique_cnt <= SPARES), with overflow and unique_cnt including any fail logged in the COLLECT->EVAL cycle.
- Both SHALL hold until clear or rst.
REQ-026 fail SHALL be ignored, including by the counters, in EVAL and REPORT.
REQ-027 rd_en SHALL be honoured only in REPORT. When !empty:
- rd_addr takes entry[rd_ptr] and rd_valid pulses on the next cycle.
- rd_ptr increments.
REQ-028 rd_en while empty or outside REPORT SHALL have no effect; rd_valid stays 0 and rd_addr holds its value.
REQ-029 empty SHALL equal (rd_ptr == wr_ptr), computed with one extra pointer bit so a full log with no reads is not empty.
REQ-030 Pops SHALL NOT change unique_cnt, total_fails or the verdict.
REQ-031 clear=1 in any state SHALL return to COLLECT next cycle, with the same output values as reset.
REQ-032 clear has priority over fail, bist_done and rd_en in the same cycle.
REQ-033 Back-to-back fail strobes on consecutive cycles SHALL each be logged; a repeat address on the very next cycle SHALL be detected as a hit.

Reset
REQ-034 rst SHALL take priority over all inputs, including clear.
REQ-035 On rst=1 at a clock edge:
- state = COLLECT.
- wr_ptr = rd_ptr = 0.
- rd_addr = 0, rd_valid = 0, empty = 1.
- unique_cnt = 0, total_fails = 0.
- overflow = 0, verdict_valid = 0, repairable = 0.
REQ-036 rst asserted mid-collection or mid-readout SHALL discard all entries; stored array contents need not be cleared.

Verification
REQ-037 No fails, then bist_done -> verdict_valid=1 two cycles later, repairable=1, empty=1, total_fails=0.
REQ-038 Fails at 0x12, 0x34, 0x12, then bist_done -> unique_cnt=2, total_fails=3, repairable=1. Pops return 0x12 then 0x34, each with a rd_valid pulse; empty=1 after.
REQ-039 Nine distinct addresses 0x00-0x08 (LOG_DEPTH=8) -> overflow=1, unique_cnt=8, repairable=0. Pops return 0x00-0x07 in order; a ninth rd_en gives no rd_valid.
REQ-040 fail at 0xFF in the same cycle as bist_done -> entry logged, unique_cnt=1, repairable=1.
REQ-041 clear issued in REPORT after three unique fails -> next cycle all outputs at reset values. A new fail at 0x05 then logs as entry 0.
REQ-042 rst asserted during a pop stream -> rd_valid=0 next cycle, empty=1, verdict_valid=0.
